// File: rtl/alien_shoot_pkg.sv
// Purpose: shared types and constants for the alien fire-request generator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alien_shoot_pkg;

    localparam int LFSR_W = 16;
    localparam int CNT_W  = 32;

    // Right-shifting Galois LFSR taps (x^16 + x^14 + x^13 + x^11 + 1), maximal length.
    localparam logic [LFSR_W-1:0] LFSR_MASK = 16'hB400;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        FIRE     = 2'd2,
        COOLDOWN = 2'd3
    } state_t;

endpackage

// File: rtl/alien_shoot_gen_lfsr16_galois.sv
// Purpose: free-running 16-bit Galois LFSR that supplies the random part of the shot interval.
// Latency: q advances once per clk after reset release; q is registered.
// Backpressure: none, never stalls.
//
// Ports: clk, reset_n (async active-low, loads SEED), q[15:0] current LFSR state.
module lfsr16_galois
    import alien_shoot_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic [LFSR_W-1:0] q
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= SEED;
        end else begin
            // Shift right; when a 1 falls out of bit 0 the tap mask is folded back in.
            q <= (q >> 1) ^ (q[0] ? LFSR_MASK : '0);
        end
    end

endmodule

// File: rtl/alien_shoot_gen.sv
// Purpose: alien fire request for the alien_shoot PIO: random wait, fixed-width shot, cooldown.
// Latency: enable sampled high at edge t -> shoot rises at edge t+I+1; shoot held HOLD_CYCLES.
// Backpressure: none; enable low returns to IDLE at the next edge, overriding all else.
//
// Ports: clk, reset_n (async active-low; release expected to be synchronised upstream),
//        enable (game running), level[1:0] (difficulty), shoot (registered fire request),
//        shot_count[15:0] (registered, wraps).
// Optional feature: define ALIEN_SHOOT_DIFFICULTY_EN to shift the random interval part
// right by level; without it level is ignored.
module alien_shoot_gen
    import alien_shoot_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED            = 16'hACE1,
    parameter int                RAND_BITS       = 4,
    parameter int                MIN_INTERVAL    = 1000,
    parameter int                HOLD_CYCLES     = 50000,
    parameter int                COOLDOWN_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [1:0]  level,
    output logic        shoot,
    output logic [15:0] shot_count
);

    generate
        if (SEED == '0) begin : g_bad_seed
            $error("alien_shoot_gen: SEED must be nonzero (all-zero LFSR locks up)");
        end
        if (RAND_BITS < 1 || RAND_BITS > LFSR_W) begin : g_bad_rand_bits
            $error("alien_shoot_gen: RAND_BITS must be in 1..16");
        end
        if (MIN_INTERVAL < 1 || HOLD_CYCLES < 1 || COOLDOWN_CYCLES < 0) begin : g_bad_timing
            $error("alien_shoot_gen: MIN_INTERVAL>=1, HOLD_CYCLES>=1, COOLDOWN_CYCLES>=0");
        end
    endgenerate

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'(COOLDOWN_CYCLES - 1);

    logic [LFSR_W-1:0]    lfsr;
    logic [RAND_BITS-1:0] rand_bits;
    logic [RAND_BITS-1:0] rand_scaled;
    logic [CNT_W-1:0]     interval;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] counter, counter_nxt;
    logic             shoot_nxt;
    logic [15:0]      shot_count_nxt;

    lfsr16_galois #(
        .SEED (SEED)
    ) u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .q       (lfsr)
    );

    assign rand_bits = lfsr[RAND_BITS-1:0];

`ifdef ALIEN_SHOOT_DIFFICULTY_EN
    // Higher level shrinks the random spread, making shots come more regularly.
    assign rand_scaled = rand_bits >> level;
`else
    logic unused_level;
    assign unused_level = ^level;
    assign rand_scaled  = rand_bits;
`endif

    // Only the low RAND_BITS of the LFSR feed the interval.
    logic unused_lfsr;
    assign unused_lfsr = ^lfsr;

    assign interval = CNT_W'(MIN_INTERVAL) + CNT_W'(rand_scaled);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            counter    <= '0;
            shoot      <= 1'b0;
            shot_count <= '0;
        end else begin
            state      <= state_nxt;
            counter    <= counter_nxt;
            shoot      <= shoot_nxt;
            shot_count <= shot_count_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        counter_nxt    = counter;
        shoot_nxt      = shoot;
        shot_count_nxt = shot_count;

        if (!enable) begin
            // Game stopped: abort immediately, even mid-shot; keep the shot tally.
            state_nxt   = IDLE;
            counter_nxt = '0;
            shoot_nxt   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt   = ARMED;
                    counter_nxt = interval;
                end
                ARMED: begin
                    if (counter != '0) begin
                        counter_nxt = counter - CNT_W'(1);
                    end else begin
                        state_nxt      = FIRE;
                        counter_nxt    = HOLD_LOAD;
                        shoot_nxt      = 1'b1;
                        shot_count_nxt = shot_count + 16'd1;
                    end
                end
                FIRE: begin
                    if (counter != '0) begin
                        counter_nxt = counter - CNT_W'(1);
                    end else begin
                        shoot_nxt = 1'b0;
                        if (COOLDOWN_CYCLES > 0) begin
                            state_nxt   = COOLDOWN;
                            counter_nxt = COOL_LOAD;
                        end else begin
                            state_nxt   = ARMED;
                            counter_nxt = interval;
                        end
                    end
                end
                COOLDOWN: begin
                    if (counter != '0) begin
                        counter_nxt = counter - CNT_W'(1);
                    end else begin
                        state_nxt   = ARMED;
                        counter_nxt = interval;
                    end
                end
                default: begin
                    state_nxt   = IDLE;
                    counter_nxt = '0;
                    shoot_nxt   = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alien_shoot_gen.sv
// Purpose: self-checking bench for alien_shoot_gen (interval, hold width, gaps, abort, reset).
// Latency: checks shoot rise at t+I+1 edges from the enable sample edge.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_alien_shoot_gen;
    import alien_shoot_pkg::*;

    localparam int          MIN_I  = 10;
    localparam int          RB     = 3;
    localparam int          HOLD   = 5;
    localparam int          CD     = 4;
    localparam logic [15:0] SEED_V = 16'hACE1;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable  = 1'b0;
    logic [1:0]  level   = 2'd0;
    logic        shoot;
    logic [15:0] shot_count;

    alien_shoot_gen #(
        .SEED            (SEED_V),
        .RAND_BITS       (RB),
        .MIN_INTERVAL    (MIN_I),
        .HOLD_CYCLES     (HOLD),
        .COOLDOWN_CYCLES (CD)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .level      (level),
        .shoot      (shoot),
        .shot_count (shot_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // Reference LFSR: lfsr_at[e] is the value the DUT sees just before edge e
    // (edges numbered from 0 after reset release).
    logic [15:0] lfsr_m;
    int          edge_n;
    logic [15:0] lfsr_at [0:8191];

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_m <= SEED_V;
            edge_n <= 0;
        end else begin
            lfsr_at[edge_n[12:0]] <= lfsr_m;
            lfsr_m                <= lfsr_step(lfsr_m);
            edge_n                <= edge_n + 1;
        end
    end

    function automatic int interval_of(input logic [15:0] l);
        int r;
        r = int'(l[RB-1:0]);
`ifdef ALIEN_SHOOT_DIFFICULTY_EN
        r = r >> level;
`endif
        return MIN_I + r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Raise enable at the current negedge; return the edge at which shoot must rise.
    task automatic start(output int exp_rise);
        enable   = 1'b1;
        exp_rise = edge_n + interval_of(lfsr_m) + 1;
    endtask

    task automatic wait_rise(output int rise, output bit ok);
        ok   = 1'b0;
        rise = -1;
        for (int i = 0; i < 60; i++) begin
            step();
            if (shoot === 1'b1) begin
                rise = edge_n - 1;
                ok   = 1'b1;
                return;
            end
        end
    endtask

    // Called on the first high sample; returns the number of high cycles and the fall edge.
    task automatic measure_high(output int h, output int fall);
        h = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (shoot !== 1'b1) break;
            h++;
        end
        fall = edge_n - 1;
    endtask

    logic [15:0] exp_shots = 16'd0;

    task automatic run_episode(input int pre_idle, input int drop_after, input int exp_high);
        int  exp_rise, rise, h;
        bit  ok;
        repeat (pre_idle) step();
        start(exp_rise);
        wait_rise(rise, ok);
        check("ep_rise_edge", ok ? rise : -1, exp_rise);
        exp_shots = exp_shots + 16'd1;
        check("ep_shot_count", 32'(shot_count), 32'(exp_shots));
        h = 1;
        while (h < drop_after) begin
            step();
            if (shoot !== 1'b1) break;
            h++;
        end
        check("ep_high_cycles", h, exp_high);
        enable = 1'b0;
        step();
        check("ep_drop_shoot", 32'(shoot), 0);
        check("ep_drop_idle", 32'(dut.state), 32'(IDLE));
    endtask

    typedef struct {
        int pre_idle;
        int drop_after;
        int exp_high;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [5];
        int   exp_rise, rise, h, fall, a, i_next, prev_fall;
        bit   ok;

        tbl[0] = '{0, 1, 1};
        tbl[1] = '{3, 2, 2};
        tbl[2] = '{1, 3, 3};
        tbl[3] = '{7, 4, 4};
        tbl[4] = '{2, 5, 5};

        // Reset, then 100 idle cycles with enable low.
        repeat (3) step();
        check("reset_shoot", 32'(shoot), 0);
        check("reset_count", 32'(shot_count), 0);
        reset_n = 1'b1;
        for (int c = 0; c < 100; c++) begin
            step();
            check("idle_shoot", 32'(shoot), 0);
            check("idle_count", 32'(shot_count), 0);
            check("idle_state", 32'(dut.state), 32'(IDLE));
        end

        // Three shots with enable held; level must be ignored without the difficulty build.
        level = 2'd3;
        start(exp_rise);
        a = edge_n;
        wait_rise(rise, ok);
        check("first_rise_edge", ok ? rise : -1, exp_rise);
        check("first_rise_window", 32'((rise >= a + 11) && (rise <= a + 18)), 1);
        exp_shots = 16'd1;
        check("first_count", 32'(shot_count), 1);
        measure_high(h, fall);
        check("first_high", h, HOLD);

        for (int s = 2; s <= 3; s++) begin
            prev_fall = fall;
            wait_rise(rise, ok);
            a      = prev_fall + CD;
            i_next = interval_of(lfsr_at[a[12:0]]);
            check("gap_len", ok ? rise - prev_fall : -1, CD + i_next + 1);
            check("gap_inext_range", 32'((i_next >= 10) && (i_next <= 17)), 1);
            exp_shots = exp_shots + 16'd1;
            check("gap_count", 32'(shot_count), 32'(exp_shots));
            if (s == 2) begin
                measure_high(h, fall);
                check("gap_high", h, HOLD);
            end
        end

        // Abort on the third FIRE cycle of shot 3.
        step();
        step();
        check("abort_pre_high", 32'(shoot), 1);
        enable = 1'b0;
        step();
        check("abort_shoot", 32'(shoot), 0);
        check("abort_state", 32'(dut.state), 32'(IDLE));
        check("abort_count", 32'(shot_count), 3);

        // Re-enable draws a fresh interval from the current LFSR.
        start(exp_rise);
        wait_rise(rise, ok);
        check("reenable_rise", ok ? rise : -1, exp_rise);
        exp_shots = exp_shots + 16'd1;
        check("reenable_count", 32'(shot_count), 32'(exp_shots));
        enable = 1'b0;
        step();
        check("reenable_drop", 32'(shoot), 0);

        for (int k = 0; k < 5; k++) begin
            run_episode(tbl[k].pre_idle, tbl[k].drop_after, tbl[k].exp_high);
        end

        for (int k = 0; k < 12; k++) begin
            int d;
            level = 2'($urandom_range(0, 3));
            d     = $urandom_range(1, 5);
            run_episode($urandom_range(0, 9), d, d);
        end

        // Async reset while ARMED: outputs clear before the next edge.
        start(exp_rise);
        repeat (3) step();
        check("armed_pre_shoot", 32'(shoot), 0);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_shoot", 32'(shoot), 0);
        check("async_rst_count", 32'(shot_count), 0);
        check("async_rst_state", 32'(dut.state), 32'(IDLE));
        enable = 1'b0;
        step();
        step();
        reset_n   = 1'b1;
        exp_shots = 16'd0;
        step();

`ifdef ALIEN_SHOOT_DIFFICULTY_EN
        level = 2'd3;
        start(exp_rise);
        a = edge_n;
        wait_rise(rise, ok);
        check("diff_rise_fixed", ok ? rise : -1, a + 11);
        enable = 1'b0;
        step();
        force dut.shot_count = 16'hFFFF;
        step();
        release dut.shot_count;
        step();
        exp_shots = 16'hFFFF;
        run_episode(1, 2, 2);
        check("wrap_zero", 32'(shot_count), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
